// File: rtl/w_writeback_port_if.sv
// M->W bundle and register-file write port of the write-back stage.
// The M stage drives the master side; the write-back stage is the slave.
interface w_writeback_port_if;
  logic        m_valid;
  logic        m_reg_we;
  logic [4:0]  m_a3;
  logic [1:0]  m_wd_sel;
  logic [2:0]  m_ld_type;
  logic [1:0]  m_addr_lo;
  logic [31:0] m_alu;
  logic [31:0] m_mem_rdata;
  logic [31:0] m_pc;
  logic        grf_we;
  logic [4:0]  grf_a3;
  logic [31:0] grf_wd;
  logic [31:0] grf_pc;
  logic [4:0]  fwd_a3;
  logic [31:0] fwd_wd;
  logic        ld_misalign;

  modport master (
    output m_valid, m_reg_we, m_a3, m_wd_sel, m_ld_type,
    output m_addr_lo, m_alu, m_mem_rdata, m_pc,
    input  grf_we, grf_a3, grf_wd, grf_pc,
    input  fwd_a3, fwd_wd, ld_misalign
  );

  modport slave (
    input  m_valid, m_reg_we, m_a3, m_wd_sel, m_ld_type,
    input  m_addr_lo, m_alu, m_mem_rdata, m_pc,
    output grf_we, grf_a3, grf_wd, grf_pc,
    output fwd_a3, fwd_wd, ld_misalign
  );
endinterface

// File: rtl/w_writeback_port.sv
// MIPS W stage: M->W register, load extraction, single GRF write port.
// Optional retire counter output enabled by WB_RETIRE_CNT_EN.
module w_writeback_port #(
  parameter logic [31:0] PC_RESET = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
`ifdef WB_RETIRE_CNT_EN
  output logic [31:0] retire_cnt,
`endif
  w_writeback_port_if.slave wb
);

  logic        valid_q;
  logic        reg_we_q;
  logic [4:0]  a3_q;
  logic [1:0]  wd_sel_q;
  logic [2:0]  ld_type_q;
  logic [1:0]  addr_lo_q;
  logic [31:0] alu_q;
  logic [31:0] rdata_q;
  logic [31:0] pc_q;

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      valid_q   <= 1'b0;
      reg_we_q  <= 1'b0;
      a3_q      <= '0;
      wd_sel_q  <= '0;
      ld_type_q <= '0;
      addr_lo_q <= '0;
      alu_q     <= '0;
      rdata_q   <= '0;
      pc_q      <= PC_RESET;
    end else if (!stall) begin
      valid_q   <= wb.m_valid;
      reg_we_q  <= wb.m_reg_we;
      a3_q      <= wb.m_a3;
      wd_sel_q  <= wb.m_wd_sel;
      ld_type_q <= wb.m_ld_type;
      addr_lo_q <= wb.m_addr_lo;
      alu_q     <= wb.m_alu;
      rdata_q   <= wb.m_mem_rdata;
      pc_q      <= wb.m_pc;
    end
  end

  logic        is_load;
  logic        is_lw;
  logic        is_half;
  logic        misalign;
  logic [7:0]  byte_v;
  logic [15:0] half_v;
  logic [31:0] ld_data;
  logic [31:0] sel_data;
  logic        we;

  assign is_load  = (wd_sel_q == 2'd1);
  assign is_lw    = (ld_type_q == 3'd0);
  assign is_half  = (ld_type_q == 3'd3) || (ld_type_q == 3'd4);
  assign misalign = is_load &&
                    ((is_lw && (addr_lo_q != 2'd0)) ||
                     (is_half && addr_lo_q[0]));

  always_comb begin
    byte_v = rdata_q[7:0];
    case (addr_lo_q)
      2'd1:    byte_v = rdata_q[15:8];
      2'd2:    byte_v = rdata_q[23:16];
      2'd3:    byte_v = rdata_q[31:24];
      default: byte_v = rdata_q[7:0];
    endcase
  end

  assign half_v = addr_lo_q[1] ? rdata_q[31:16] : rdata_q[15:0];

  always_comb begin
    ld_data = rdata_q;
    case (ld_type_q)
      3'd1:    ld_data = {{24{byte_v[7]}}, byte_v};
      3'd2:    ld_data = {24'd0, byte_v};
      3'd3:    ld_data = {{16{half_v[15]}}, half_v};
      3'd4:    ld_data = {16'd0, half_v};
      default: ld_data = rdata_q;
    endcase
  end

  always_comb begin
    sel_data = '0;
    unique case (1'b1)
      (wd_sel_q == 2'd0): sel_data = alu_q;
      (wd_sel_q == 2'd1): sel_data = ld_data;
      (wd_sel_q == 2'd2): sel_data = pc_q + 32'd8;
      (wd_sel_q == 2'd3): sel_data = '0;
    endcase
  end

  assign we = valid_q && reg_we_q &&
              (a3_q != 5'd0) && !misalign;

  assign wb.grf_we      = we;
  assign wb.grf_a3      = we ? a3_q : 5'd0;
  assign wb.grf_wd      = we ? sel_data : 32'd0;
  assign wb.grf_pc      = pc_q;
  assign wb.fwd_a3      = wb.grf_a3;
  assign wb.fwd_wd      = wb.grf_wd;
  assign wb.ld_misalign = misalign;

`ifdef WB_RETIRE_CNT_EN
  logic [31:0] retire_cnt_q;
  logic [31:0] retire_cnt_d;

  // A stalled cycle re-presents the same write; count it only once.
  assign retire_cnt_d = (we && !stall) ? retire_cnt_q + 32'd1
                                       : retire_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) retire_cnt_q <= '0;
    else       retire_cnt_q <= retire_cnt_d;
  end

  assign retire_cnt = retire_cnt_q;
`endif

endmodule

// File: tb/tb_w_writeback_port.sv
// Directed vector bench for the W stage.
// Table of single-cycle cases plus stall/flush/reset sequences.
module tb_w_writeback_port;

  logic clk = 1'b0;
  logic reset;
  logic stall;
  logic flush;
`ifdef WB_RETIRE_CNT_EN
  logic [31:0] retire_cnt;
`endif

  int total = 0;
  int bad = 0;

  w_writeback_port_if wb();

  w_writeback_port dut (
    .clk   (clk),
    .reset (reset),
    .stall (stall),
    .flush (flush),
`ifdef WB_RETIRE_CNT_EN
    .retire_cnt (retire_cnt),
`endif
    .wb    (wb.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        reg_we;
    logic [4:0]  a3;
    logic [1:0]  wd_sel;
    logic [2:0]  ld_type;
    logic [1:0]  addr_lo;
    logic [31:0] alu;
    logic [31:0] rdata;
    logic [31:0] pc;
    logic        e_we;
    logic [4:0]  e_a3;
    logic [31:0] e_wd;
    logic        e_mis;
  } vec_t;

  vec_t vq[$];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic we,
                       input logic [4:0] a3,
                       input logic [1:0] sel,
                       input logic [2:0] lt,
                       input logic [1:0] lo,
                       input logic [31:0] alu,
                       input logic [31:0] rd,
                       input logic [31:0] pc);
    wb.m_valid     = v;
    wb.m_reg_we    = we;
    wb.m_a3        = a3;
    wb.m_wd_sel    = sel;
    wb.m_ld_type   = lt;
    wb.m_addr_lo   = lo;
    wb.m_alu       = alu;
    wb.m_mem_rdata = rd;
    wb.m_pc        = pc;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string nm,
                         input logic we,
                         input logic [4:0] a3,
                         input logic [31:0] wd,
                         input logic [31:0] pc,
                         input logic mis);
    chk({nm, ".we"},  {31'd0, wb.grf_we}, {31'd0, we});
    chk({nm, ".a3"},  {27'd0, wb.grf_a3}, {27'd0, a3});
    chk({nm, ".wd"},  wb.grf_wd, wd);
    chk({nm, ".pc"},  wb.grf_pc, pc);
    chk({nm, ".fa3"}, {27'd0, wb.fwd_a3}, {27'd0, a3});
    chk({nm, ".fwd"}, wb.fwd_wd, wd);
    chk({nm, ".mis"}, {31'd0, wb.ld_misalign}, {31'd0, mis});
  endtask

  localparam logic [31:0] RD = 32'h80FF_7F01;

  initial begin
    vq.push_back('{1, 8, 0, 0, 0, 32'h1234_5678, RD, 32'h3004,
                   1, 8, 32'h1234_5678, 0});
    vq.push_back('{1, 2, 1, 1, 3, 0, RD, 32'h3008, 1, 2, 32'hFFFF_FF80, 0});
    vq.push_back('{1, 3, 1, 2, 3, 0, RD, 32'h300C, 1, 3, 32'h0000_0080, 0});
    vq.push_back('{1, 4, 1, 3, 2, 0, RD, 32'h3010, 1, 4, 32'hFFFF_80FF, 0});
    vq.push_back('{1, 5, 1, 4, 0, 0, RD, 32'h3014, 1, 5, 32'h0000_7F01, 0});
    vq.push_back('{1, 6, 1, 0, 2, 0, RD, 32'h3018, 0, 0, 32'h0, 1});
    vq.push_back('{1, 0, 0, 0, 0, 32'h5, RD, 32'h301C, 0, 0, 32'h0, 0});
    vq.push_back('{1, 31, 2, 0, 0, 0, RD, 32'h3010, 1, 31, 32'h3018, 0});
    vq.push_back('{1, 31, 2, 0, 0, 0, RD, 32'hFFFF_FFFC, 1, 31, 32'h4, 0});
    vq.push_back('{1, 7, 1, 1, 1, 0, RD, 32'h3020, 1, 7, 32'h0000_007F, 0});
    vq.push_back('{1, 9, 1, 0, 0, 0, RD, 32'h3024, 1, 9, RD, 0});
    vq.push_back('{1, 10, 1, 3, 1, 0, RD, 32'h3028, 0, 0, 32'h0, 1});
    vq.push_back('{1, 11, 3, 0, 0, 32'h77, RD, 32'h302C, 1, 11, 32'h0, 0});
    vq.push_back('{0, 12, 0, 0, 0, 32'h77, RD, 32'h3030, 0, 0, 32'h0, 0});
    vq.push_back('{1, 13, 1, 5, 1, 0, RD, 32'h3034, 1, 13, RD, 0});
    vq.push_back('{1, 14, 1, 1, 0, 0, RD, 32'h3038, 1, 14, 32'h1, 0});
    vq.push_back('{1, 15, 1, 4, 3, 0, RD, 32'h303C, 0, 0, 32'h0, 1});
    vq.push_back('{1, 16, 1, 4, 2, 0, RD, 32'h3040, 1, 16, 32'h0000_80FF, 0});
    vq.push_back('{1, 17, 0, 1, 1, 32'hCAFE, RD, 32'h3044, 1, 17, 32'hCAFE, 0});

    reset = 1'b1;
    stall = 1'b0;
    flush = 1'b0;
    drive(1, 1, 5'd3, 2'd0, 3'd0, 2'd0, 32'hDEAD, RD, 32'h1000);
    step();
    step();
    chk_out("reset", 0, 0, 0, 32'h3000, 0);

    @(negedge clk);
    reset = 1'b0;
    foreach (vq[i]) begin
      drive(1, vq[i].reg_we, vq[i].a3, vq[i].wd_sel, vq[i].ld_type,
            vq[i].addr_lo, vq[i].alu, vq[i].rdata, vq[i].pc);
      step();
      chk_out($sformatf("vec%0d", i), vq[i].e_we, vq[i].e_a3,
              vq[i].e_wd, vq[i].pc, vq[i].e_mis);
      @(negedge clk);
    end

    drive(0, 1, 5'd8, 2'd0, 3'd0, 2'd0, 32'h55, RD, 32'h3100);
    step();
    chk_out("novalid", 0, 0, 0, 32'h3100, 0);

    @(negedge clk);
    drive(1, 1, 5'd9, 2'd0, 3'd0, 2'd0, 32'hAAAA_5555, RD, 32'h3200);
    step();
    chk_out("prestall", 1, 9, 32'hAAAA_5555, 32'h3200, 0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      stall = 1'b1;
      drive(1, 1, 5'(20 + k), 2'd2, 3'd0, 2'd0,
            32'h100 * k, RD, 32'h4000 + k);
      step();
      chk_out($sformatf("stall%0d", k), 1, 9, 32'hAAAA_5555, 32'h3200, 0);
    end

    @(negedge clk);
    flush = 1'b1;
    step();
    chk_out("stallflush", 0, 0, 0, 32'h3000, 0);

    @(negedge clk);
    stall = 1'b0;
    flush = 1'b0;
    drive(1, 1, 5'd12, 2'd0, 3'd0, 2'd0, 32'h1111, RD, 32'h3300);
    step();
    chk_out("preflush", 1, 12, 32'h1111, 32'h3300, 0);
    @(negedge clk);
    flush = 1'b1;
    step();
    chk_out("flush", 0, 0, 0, 32'h3000, 0);

    @(negedge clk);
    flush = 1'b0;
    drive(1, 1, 5'd13, 2'd0, 3'd0, 2'd0, 32'h2222, RD, 32'h3400);
    step();
    chk_out("prereset", 1, 13, 32'h2222, 32'h3400, 0);
    @(negedge clk);
    reset = 1'b1;
    drive(1, 1, 5'd14, 2'd0, 3'd0, 2'd0, 32'h3333, RD, 32'h3500);
    step();
    chk_out("midreset", 0, 0, 0, 32'h3000, 0);

`ifdef WB_RETIRE_CNT_EN
    chk("cnt.reset", retire_cnt, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 6; k++) begin
      stall = (k == 2);
      drive(k < 5, 1, 5'(k + 1), 2'd0, 3'd0, 2'd0,
            32'(k), RD, 32'h3600);
      step();
      @(negedge clk);
    end
    stall = 1'b0;
    chk("cnt.five", retire_cnt, 32'd4);
    step();
    chk("cnt.hold", retire_cnt, 32'd4);

    @(negedge clk);
    drive(1, 1, 5'd4, 2'd0, 3'd0, 2'd0, 32'h9, RD, 32'h3700);
    step();
    @(negedge clk);
    dut.retire_cnt_q = 32'hFFFF_FFFF;
    drive(0, 0, 5'd0, 2'd0, 3'd0, 2'd0, 32'h0, RD, 32'h3704);
    step();
    chk("cnt.wrap", retire_cnt, 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/w_writeback_port.md
Name: w_writeback_port

Overview:
- Write-back stage of the 5-stage pipelined MIPS core.
- Holds the M→W pipeline register and selects the write-back source: ALU result, sign- or zero-extended load data, or PC+8.
- Drives the register file write port (WE, A3, WD, PC) and is the single writer of that port.
- Also supplies the W-stage forwarding address and data.

Parameters:
- PC_RESET, 32'h0000_3000, value of the registered PC after reset or flush.

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- stall  in  1  hold the W register
- flush  in  1  load a bubble into the W register
- m_valid  in  1  M stage holds a real instruction
- m_reg_we  in  1  instruction writes a GPR
- m_a3  in  5  destination register
- m_wd_sel  in  2  source: 0 ALU, 1 MEM, 2 PC+8, 3 reserved
- m_ld_type  in  3  0 lw, 1 lb, 2 lbu, 3 lh, 4 lhu; others reserved
- m_addr_lo  in  2  low bits of the load address
- m_alu  in  32  ALU result
- m_mem_rdata  in  32  raw data-memory word
- m_pc  in  32  instruction PC
- grf_we  out  1  register-file write enable
- grf_a3  out  5  register-file write address
- grf_wd  out  32  register-file write data
- grf_pc  out  32  PC of the writing instruction
- fwd_a3  out  5  forwarding address; 0 when no write
- fwd_wd  out  32  forwarding data, equal to grf_wd
- ld_misalign  out  1  registered load is misaligned

Behaviour:
- W register fields: valid, reg_we, a3, wd_sel, ld_type, addr_lo, alu, rdata, pc.
- Captures the M-stage inputs on posedge clk.
- Priority: reset > flush > stall > capture.
- Reset and flush both load: valid=0, reg_we=0, a3=0, wd_sel=0, ld_type=0, addr_lo=0, alu=0, rdata=0, pc=PC_RESET.
- Stall: all fields hold.
- Reset values of outputs: grf_we=0, grf_a3=0, grf_wd=0, grf_pc=PC_RESET, fwd_a3=0, fwd_wd=0, ld_misalign=0.
- Outputs are combinational from the W register only. The path from M-stage inputs to outputs has 1 cycle latency.
- Misalignment, evaluated only when wd_sel=1:
  - ld_misalign=1 if lw with addr_lo≠0.
  - ld_misalign=1 if lh/lhu with addr_lo[0]=1.
  - Byte loads are never misaligned.
  - ld_misalign=0 whenever wd_sel≠1.
- grf_we = valid & reg_we & (a3≠0) & ~ld_misalign.
- grf_a3 = a3 when grf_we=1, else 0.
- Load extraction is little-endian:
  - Byte lane = addr_lo, i.e. rdata[8·addr_lo+7 : 8·addr_lo].
  - Halfword = rdata[31:16] if addr_lo[1]=1, else rdata[15:0].
  - lb/lh: sign-extend to 32 bits. lbu/lhu: zero-extend.
  - Reserved ld_type: pass the full word.
- Write data selection:
  - wd_sel 0 → alu.
  - wd_sel 1 → extracted load data.
  - wd_sel 2 → pc+8, 32-bit wrap (32'hFFFF_FFFC+8 = 32'h0000_0004).
  - wd_sel 3 → 0.
- grf_wd = selected data when grf_we=1, else 0. fwd_wd = grf_wd.
- grf_pc = pc always. fwd_a3 = grf_a3.
- Writes to $0 are suppressed here; the register file performs no further filtering and does not need to.
- Stall held over multiple cycles: grf_we stays asserted every cycle with identical a3/wd. The repeated write is idempotent; no deduplication.
- Stall and flush in the same cycle: flush wins and the bubble is loaded.
- Reset asserted mid-stream: the next edge clears the register. Any pending write is dropped and never reaches the register file.

Optional Feature:
- Macro: WB_RETIRE_CNT_EN.
- Defined:
  - Adds output retire_cnt (32 bits, reset 0).
  - retire_cnt increments on every posedge where grf_we=1 and stall=0.
  - Wraps 32'hFFFF_FFFF→0.
  - Reset takes priority over increment.
- Undefined: the port and the counter are absent; all other behaviour is identical.

Test Plan:
- ALU write: m_valid=1, reg_we=1, a3=8, wd_sel=0, alu=32'h1234_5678, pc=32'h0000_3004 → next cycle grf_we=1, grf_a3=8, grf_wd=32'h1234_5678, grf_pc=32'h0000_3004.
- Byte/half loads with rdata=32'h80FF_7F01:
  - lb, addr_lo=3 → grf_wd=32'hFFFF_FF80.
  - lbu, addr_lo=3 → 32'h0000_0080.
  - lh, addr_lo=2 → 32'hFFFF_80FF.
  - lhu, addr_lo=0 → 32'h0000_7F01.
- Misaligned and $0:
  - lw, addr_lo=2 → ld_misalign=1, grf_we=0, grf_wd=0.
  - a3=0 with reg_we=1 → grf_we=0, fwd_a3=0.
- jal link: wd_sel=2, pc=32'h0000_3010, a3=31 → grf_wd=32'h0000_3018. Repeat with pc=32'hFFFF_FFFC → 32'h0000_0004.
- Stall/flush/reset:
  - Valid write registered, then stall=1 for 3 cycles with changing M inputs → outputs unchanged for all 3 cycles.
  - stall=1 and flush=1 together → bubble: grf_we=0, grf_pc=32'h0000_3000.
  - reset during a pending write → grf_we=0 after the edge.
- WB_RETIRE_CNT_EN defined:
  - 5 valid writes, one of them during a stall → retire_cnt=4.
  - Preload to 32'hFFFF_FFFF, then one write → 0.
